lcd_bus_receiver: RTL and testbench

- Responder end of the HD44780-style parallel LCD bus driven by our LCD driver: decodes rs/rw/e/data writes into a 2x16 character mirror RAM plus display-state registers.
- Used as a synthesizable display mirror, for example as the source for a second display.
- Serves as the checking model in top-level benches: rd_char read back at index n must equal the character the mode block supplied for index n.

---
 rtl/lcd_bus_receiver.sv | 234 +++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: responder end of an HD44780-style parallel LCD bus.
// Mirrors a 2x16 character RAM plus the display-state registers.
//
// Ports:
//   clk, rst          system clock, async active-high reset
//   lcd_rs/rw/e/data  bus inputs (asynchronous, synchronized here)
//   rd_index, rd_char mirror read port, 1-clk registered latency
//   ddram_addr        address counter
//   disp_on, cursor_on, blink_on, entry_inc  display-state bits
//   busy              clear-display fill in progress
//   overrun           sticky, a write strobe was dropped during fill
//   cmd_strobe        one-cycle pulse per accepted write transfer
module lcd_bus_receiver #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char,
    output logic [6:0] ddram_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       overrun,
    output logic       cmd_strobe
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam int L = SYNC_STAGES - 1;

    // Synchronizer chains; all four buses share the same depth so the
    // rs/rw/data seen with the falling e are the ones launched with it.
    logic [L:0]      e_sync_q, e_sync_d;
    logic [L:0]      rs_sync_q, rs_sync_d;
    logic [L:0]      rw_sync_q, rw_sync_d;
    logic [L:0][7:0] dt_sync_q, dt_sync_d;

    logic       e_prev_q, e_prev_d;
    logic       xfer_q, xfer_d;
    logic       xrs_q, xrs_d;
    logic       xrw_q, xrw_d;
    logic [7:0] xdata_q, xdata_d;

    state_t     state_q, state_d;
    logic [4:0] fill_q, fill_d;
    logic [7:0] mem_q [32];
    logic [7:0] mem_d [32];
    logic [7:0] rd_char_q, rd_char_d;
    logic [6:0] addr_q, addr_d;
    logic       disp_q, disp_d;
    logic       cur_q, cur_d;
    logic       blink_q, blink_d;
    logic       inc_q, inc_d;
    logic       cg_q, cg_d;
    logic       ovr_q, ovr_d;
    logic       strobe_q, strobe_d;

    // Address counter step with the HD44780 two-line wrap points.
    function automatic logic [6:0] addr_step(input logic [6:0] a,
                                             input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    always_comb begin
        if (L == 0) begin
            e_sync_d  = lcd_e;
            rs_sync_d = lcd_rs;
            rw_sync_d = lcd_rw;
            dt_sync_d = lcd_data;
        end else begin
            e_sync_d  = {e_sync_q[L-1:0], lcd_e};
            rs_sync_d = {rs_sync_q[L-1:0], lcd_rs};
            rw_sync_d = {rw_sync_q[L-1:0], lcd_rw};
            dt_sync_d = {dt_sync_q[L-1:0], lcd_data};
        end
        e_prev_d = e_sync_q[L];
        // Detected fall is registered with its aligned bus values and
        // executed one clk later.
        xfer_d  = e_prev_q & ~e_sync_q[L];
        xrs_d   = rs_sync_q[L];
        xrw_d   = rw_sync_q[L];
        xdata_d = dt_sync_q[L];
    end

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        mem_d     = mem_q;
        addr_d    = addr_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        inc_d     = inc_q;
        cg_d      = cg_q;
        ovr_d     = ovr_q;
        strobe_d  = 1'b0;
        rd_char_d = mem_q[rd_index];

        unique case (state_q)
            ST_IDLE: begin
                if (xfer_q && !xrw_q) begin
                    strobe_d = 1'b1;
                    if (xrs_q) begin
                        if (!cg_q) begin
                            if (addr_q[6:4] == 3'b000)
                                mem_d[{1'b0, addr_q[3:0]}] = xdata_q;
                            else if (addr_q[6:4] == 3'b100)
                                mem_d[{1'b1, addr_q[3:0]}] = xdata_q;
                            addr_d = addr_step(addr_q, inc_q);
                        end
                    end else begin
                        priority case (1'b1)
                            xdata_q[7]: begin
                                addr_d = xdata_q[6:0];
                                cg_d   = 1'b0;
                            end
                            xdata_q[6]: cg_d = 1'b1;
                            xdata_q[5]: ;
                            xdata_q[4]: begin
                                if (!xdata_q[3])
                                    addr_d = addr_step(addr_q, xdata_q[2]);
                            end
                            xdata_q[3]: begin
                                disp_d  = xdata_q[2];
                                cur_d   = xdata_q[1];
                                blink_d = xdata_q[0];
                            end
                            xdata_q[2]: inc_d = xdata_q[1];
                            xdata_q[1]: addr_d = 7'h00;
                            xdata_q[0]: begin
                                addr_d  = 7'h00;
                                inc_d   = 1'b1;
                                cg_d    = 1'b0;
                                fill_d  = 5'd0;
                                state_d = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                mem_d[fill_q] = BLANK_CHAR;
                fill_d = fill_q + 5'd1;
                if (fill_q == 5'd31)
                    state_d = ST_IDLE;
                if (xfer_q && !xrw_q)
                    ovr_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_sync_q  <= '0;
            rs_sync_q <= '0;
            rw_sync_q <= '0;
            dt_sync_q <= '0;
            e_prev_q  <= 1'b0;
            xfer_q    <= 1'b0;
            xrs_q     <= 1'b0;
            xrw_q     <= 1'b0;
            xdata_q   <= 8'h00;
            state_q   <= ST_IDLE;
            fill_q    <= 5'd0;
            for (int i = 0; i < 32; i++)
                mem_q[i] <= BLANK_CHAR;
            rd_char_q <= BLANK_CHAR;
            addr_q    <= 7'h00;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            inc_q     <= 1'b1;
            cg_q      <= 1'b0;
            ovr_q     <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            e_sync_q  <= e_sync_d;
            rs_sync_q <= rs_sync_d;
            rw_sync_q <= rw_sync_d;
            dt_sync_q <= dt_sync_d;
            e_prev_q  <= e_prev_d;
            xfer_q    <= xfer_d;
            xrs_q     <= xrs_d;
            xrw_q     <= xrw_d;
            xdata_q   <= xdata_d;
            state_q   <= state_d;
            fill_q    <= fill_d;
            mem_q     <= mem_d;
            rd_char_q <= rd_char_d;
            addr_q    <= addr_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            inc_q     <= inc_d;
            cg_q      <= cg_d;
            ovr_q     <= ovr_d;
            strobe_q  <= strobe_d;
        end
    end

    assign rd_char    = rd_char_q;
    assign ddram_addr = addr_q;
    assign disp_on    = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign entry_inc  = inc_q;
    assign busy       = (state_q == ST_CLEAR);
    assign overrun    = ovr_q;
    assign cmd_strobe = strobe_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: scoreboard bench for lcd_bus_receiver.
// Directed plan followed by random bus traffic against a reference model.
module tb_lcd_bus_receiver;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic [4:0] rd_index;
    logic [7:0] rd_char;
    logic [6:0] ddram_addr;
    logic       disp_on, cursor_on, blink_on, entry_inc;
    logic       busy, overrun, cmd_strobe;

    always #5 clk = ~clk;

    lcd_bus_receiver #(.SYNC_STAGES(S), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .rd_index(rd_index), .rd_char(rd_char),
        .ddram_addr(ddram_addr), .disp_on(disp_on),
        .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .busy(busy), .overrun(overrun),
        .cmd_strobe(cmd_strobe)
    );

    typedef struct {
        int addr;
        bit d, c, b, inc;
    } exp_t;
    exp_t exp_q[$];

    int  m_ram[32];
    int  m_addr;
    bit  m_d, m_c, m_b, m_inc, m_cg, m_ovr;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int next_addr(input int a, input bit inc);
        if (inc) begin
            if (a == 'h27) return 'h40;
            if (a == 'h67) return 0;
            return (a + 1) % 128;
        end
        if (a == 0)    return 'h67;
        if (a == 'h40) return 'h27;
        return (a + 127) % 128;
    endfunction

    function automatic int ram_idx(input int a);
        if (a < 16) return a;
        if (a >= 'h40 && a < 'h50) return 16 + a - 'h40;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 'h20;
        m_addr = 0;
        m_d = 0; m_c = 0; m_b = 0;
        m_inc = 1; m_cg = 0; m_ovr = 0;
    endtask

    task automatic model_apply(input bit rs, input bit [7:0] d);
        exp_t e;
        int idx;
        if (rs) begin
            if (!m_cg) begin
                idx = ram_idx(m_addr);
                if (idx >= 0) m_ram[idx] = d;
                m_addr = next_addr(m_addr, m_inc);
            end
        end else if (d >= 128) begin
            m_addr = d - 128;
            m_cg = 0;
        end else if (d >= 64) begin
            m_cg = 1;
        end else if (d >= 32) begin
            m_cg = m_cg;
        end else if (d >= 16) begin
            if (d[3] == 1'b0) m_addr = next_addr(m_addr, d[2]);
        end else if (d >= 8) begin
            m_d = d[2]; m_c = d[1]; m_b = d[0];
        end else if (d >= 4) begin
            m_inc = d[1];
        end else if (d >= 2) begin
            m_addr = 0;
        end else if (d == 1) begin
            for (int i = 0; i < 32; i++) m_ram[i] = 'h20;
            m_addr = 0; m_inc = 1; m_cg = 0;
        end
        e.addr = m_addr; e.d = m_d; e.c = m_c; e.b = m_b; e.inc = m_inc;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expected response.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (!rst && cmd_strobe) begin
            exp_t e;
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_addr", int'(ddram_addr), e.addr);
                check("strobe_flags",
                      int'({disp_on, cursor_on, blink_on, entry_inc}),
                      int'({e.d, e.c, e.b, e.inc}));
            end
        end
    end

    task automatic pulse(input bit rs, input bit rw, input bit [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("clear_done", int'(busy), 0);
    endtask

    task automatic xfer(input bit rs, input bit rw, input bit [7:0] d);
        if (!rw) model_apply(rs, d);
        pulse(rs, rw, d);
        repeat (S + 2) @(negedge clk);
        if (!rs && !rw && d == 8'h01) wait_idle();
    endtask

    task automatic read_check(input int i, input int exp);
        @(negedge clk);
        rd_index = 5'(i);
        @(negedge clk);
        check($sformatf("rd_char[%0d]", i), int'(rd_char), exp);
    endtask

    task automatic check_ram();
        for (int i = 0; i < 32; i++) read_check(i, m_ram[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_char"}, int'(rd_char), 'h20);
        check({tag, "_addr"}, int'(ddram_addr), 0);
        check({tag, "_dcb"}, int'({disp_on, cursor_on, blink_on}), 0);
        check({tag, "_inc"}, int'(entry_inc), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_strobe"}, int'(cmd_strobe), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit rs, rw;
        bit [7:0] d;
        rst = 1'b1;
        lcd_rs = 0; lcd_rw = 0; lcd_e = 0; lcd_data = 0; rd_index = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        check_ram();

        // Plan 1: set address 0, write "HI".
        s0 = strobe_cnt;
        xfer(0, 0, 8'h80);
        xfer(1, 0, 8'h48);
        xfer(1, 0, 8'h49);
        read_check(0, 'h48);
        read_check(1, 'h49);
        check("t1_addr", int'(ddram_addr), 2);
        check("t1_strobes", strobe_cnt - s0, 3);

        // Plan 2: end of line 2, second write falls off the window.
        xfer(0, 0, 8'hCF);
        xfer(1, 0, 8'h41);
        xfer(1, 0, 8'h42);
        read_check(31, 'h41);
        check("t2_addr", int'(ddram_addr), 'h51);

        // Plan 3: decrement wrap then shift-right wrap.
        xfer(0, 0, 8'h04);
        xfer(0, 0, 8'h80);
        xfer(1, 0, 8'h5A);
        read_check(0, 'h5A);
        check("t3_addr", int'(ddram_addr), 'h67);
        xfer(0, 0, 8'h14);
        check("t3_shift", int'(ddram_addr), 0);

        // Plan 4: fill, clear with a dropped strobe during the fill.
        xfer(0, 0, 8'h06);
        xfer(0, 0, 8'h80);
        for (int i = 0; i < 16; i++) xfer(1, 0, 8'($urandom_range(33, 126)));
        xfer(0, 0, 8'hC0);
        for (int i = 0; i < 16; i++) xfer(1, 0, 8'($urandom_range(33, 126)));
        check_ram();
        busy_cnt = 0;
        model_apply(0, 8'h01);
        pulse(0, 0, 8'h01);
        pulse(1, 0, 8'h77);
        m_ovr = 1;
        repeat (S + 2) @(negedge clk);
        wait_idle();
        check("t4_busy_clks", busy_cnt, 32);
        check("t4_overrun", int'(overrun), int'(m_ovr));
        check("t4_addr", int'(ddram_addr), 0);
        check_ram();

        // Plan 5: display control, CGRAM-mode data discard.
        xfer(0, 0, 8'h0F);
        check("t5_dcb_on", int'({disp_on, cursor_on, blink_on}), 7);
        xfer(0, 0, 8'h0C);
        check("t5_dcb_dsp", int'({disp_on, cursor_on, blink_on}), 4);
        xfer(0, 0, 8'h40);
        xfer(1, 0, 8'h55);
        check("t5_addr", int'(ddram_addr), m_addr);
        check_ram();

        // Plan 6: reset in the middle of a fill with a strobe pending.
        model_apply(0, 8'h01);
        pulse(0, 0, 8'h01);
        @(negedge clk);
        lcd_rs = 1; lcd_rw = 0; lcd_data = 8'h33; lcd_e = 1;
        repeat (3) @(negedge clk);
        lcd_e = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        s0 = strobe_cnt;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (20) @(negedge clk);
        check("t6_no_late_strobe", strobe_cnt - s0, 0);
        check("t6_overrun", int'(overrun), 0);
        check_ram();

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            rs = 1'($urandom % 2);
            rw = ($urandom % 10) == 0;
            d  = 8'($urandom);
            if (!rs && ($urandom % 3) == 0)
                d = 8'h80 | 8'(($urandom % 2) * 'h40) | 8'($urandom % 17);
            xfer(rs, rw, d);
        end
        check("rand_addr", int'(ddram_addr), m_addr);
        check("rand_flags",
              int'({disp_on, cursor_on, blink_on, entry_inc}),
              int'({m_d, m_c, m_b, m_inc}));
        check("rand_overrun", int'(overrun), int'(m_ovr));
        check_ram();
        check("pending_expect", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
